// File: rtl/ext_bus_pkg.sv
// Shared definitions for the external bus bridge: FSM state encoding,
// wait-counter width and helpers deriving lane count/index width from RV.
package ext_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AHI  = 3'd1,
    S_ALO  = 3'd2,
    S_WDAT = 3'd3,
    S_RDAT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam int WC_W = 3;

  function automatic int nb_of(input int rv);
    return rv / 8;
  endfunction

  function automatic int iw_of(input int rv);
    return (rv == 32) ? 2 : 1;
  endfunction

endpackage

// File: rtl/ext_bus_lane_seq.sv
// Byte-lane sequencer: lowest enabled lane, next enabled lane above the
// current one on a step, and a flag when no enabled lane remains above.
module ext_bus_lane_seq #(
  parameter int NB = 2,
  parameter int IW = 1
) (
  input  logic [NB-1:0] i_mask,
  input  logic [IW-1:0] i_lane,
  input  logic          i_step,
  output logic [IW-1:0] o_lane,
  output logic          o_last,
  output logic [IW-1:0] o_first
);

  logic [IW-1:0] w_above;
  logic          w_found;

  // Descending scan so the lowest qualifying index is the one that sticks.
  always_comb begin
    w_above = i_lane;
    w_found = 1'b0;
    o_first = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (i_mask[i]) o_first = IW'(i);
      if (i_mask[i] && (IW'(i) > i_lane)) begin
        w_above = IW'(i);
        w_found = 1'b1;
      end
    end
  end

  assign o_lane = (i_step && w_found) ? w_above : i_lane;
  assign o_last = !w_found;

endmodule

// File: rtl/ext_bus_bridge.sv
// CPU word read / byte-masked write serialiser onto an 8-bit multiplexed bus.
// Optional EXT_BUS_READY_EN adds bus_ready to stretch the last cycle of each data lane.
module ext_bus_bridge
  import ext_bus_pkg::*;
#(
  parameter int RV          = 16,
  parameter int WAIT_CYCLES = 0,
  localparam int NB = nb_of(RV),
  localparam int IW = iw_of(RV)
) (
  input  logic          clk,
  input  logic          reset_in,
  input  logic [15:IW]  raddr,
  input  logic          rreq,
  output logic [RV-1:0] rdata,
  output logic          rdone,
  input  logic [15:IW]  waddr,
  input  logic [NB-1:0] wmask,
  input  logic [RV-1:0] wdata,
  output logic          wdone,
  output logic [7:0]    bus_out,
  input  logic [7:0]    bus_in,
`ifdef EXT_BUS_READY_EN
  input  logic          bus_ready,
`endif
  output logic          latch_hi,
  output logic          latch_lo,
  output logic          write,
  output logic [IW-1:0] ind
);

  state_t            r_state, w_state_d;
  logic              r_is_wr;
  logic [15:IW]      r_addr;
  logic [RV-1:0]     r_wdata, r_rbuf, r_rdata, w_rbuf_d;
  logic [NB-1:0]     r_mask, w_seq_mask;
  logic [IW-1:0]     r_lane, w_lane_d, w_lane_nxt, w_first;
  logic [WC_W-1:0]   r_wcnt, w_wcnt_d;
  logic [7:0]        r_bus, w_bus_d;
  logic              r_lhi, r_llo, r_wr, r_rdone, r_wdone;
  logic              w_lhi_d, w_llo_d, w_wr_d, w_rdone_d, w_wdone_d;
  logic [IW-1:0]     r_ind, w_ind_d;
  logic              w_cap_wr, w_cap_rd, w_last, w_ready, w_lane_end;

`ifdef EXT_BUS_READY_EN
  assign w_ready = bus_ready;
`else
  assign w_ready = 1'b1;
`endif

  assign w_lane_end = (r_wcnt == WC_W'(WAIT_CYCLES)) && w_ready;
  assign w_seq_mask = r_is_wr ? r_mask : '1;

  ext_bus_lane_seq #(.NB(NB), .IW(IW)) u_lane_seq (
    .i_mask  (w_seq_mask),
    .i_lane  (r_lane),
    .i_step  (w_lane_end),
    .o_lane  (w_lane_nxt),
    .o_last  (w_last),
    .o_first (w_first)
  );

  // Next state and next registered output values.
  always_comb begin
    w_state_d = r_state;
    w_bus_d   = '0;
    w_lhi_d   = 1'b0;
    w_llo_d   = 1'b0;
    w_wr_d    = 1'b0;
    w_ind_d   = '0;
    w_rdone_d = 1'b0;
    w_wdone_d = 1'b0;
    w_lane_d  = r_lane;
    w_wcnt_d  = r_wcnt;
    w_cap_wr  = 1'b0;
    w_cap_rd  = 1'b0;
    w_rbuf_d  = r_rbuf;
    case (r_state)
      S_IDLE: begin
        if (|wmask) begin
          w_cap_wr  = 1'b1;
          w_state_d = S_AHI;
          w_bus_d   = waddr[15:8];
          w_lhi_d   = 1'b1;
        end else if (rreq) begin
          w_cap_rd  = 1'b1;
          w_state_d = S_AHI;
          w_bus_d   = raddr[15:8];
          w_lhi_d   = 1'b1;
        end
      end
      S_AHI: begin
        w_state_d = S_ALO;
        w_bus_d   = {r_addr[7:IW], {IW{1'b0}}};
        w_llo_d   = 1'b1;
      end
      S_ALO: begin
        w_state_d = r_is_wr ? S_WDAT : S_RDAT;
        w_lane_d  = w_first;
        w_wcnt_d  = '0;
        w_ind_d   = w_first;
        w_wr_d    = r_is_wr;
        w_bus_d   = r_is_wr ? r_wdata[8*w_first +: 8] : 8'h00;
      end
      S_WDAT, S_RDAT: begin
        if (w_lane_end) begin
          w_wcnt_d = '0;
          if (!r_is_wr) w_rbuf_d[8*r_lane +: 8] = bus_in;
          if (w_last) begin
            w_state_d = S_DONE;
            w_wdone_d = r_is_wr;
            w_rdone_d = !r_is_wr;
          end else begin
            w_lane_d = w_lane_nxt;
          end
        end else if (r_wcnt != WC_W'(WAIT_CYCLES)) begin
          w_wcnt_d = r_wcnt + 1'b1;
        end
        if (w_state_d != S_DONE) begin
          w_ind_d = w_lane_d;
          w_wr_d  = r_is_wr;
          w_bus_d = r_is_wr ? r_wdata[8*w_lane_d +: 8] : 8'h00;
        end
      end
      S_DONE: begin
        w_state_d = S_IDLE;
        w_lane_d  = '0;
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      r_state <= S_IDLE;
      r_bus   <= '0;
      r_lhi   <= 1'b0;
      r_llo   <= 1'b0;
      r_wr    <= 1'b0;
      r_ind   <= '0;
      r_rdone <= 1'b0;
      r_wdone <= 1'b0;
      r_rdata <= '0;
      r_lane  <= '0;
      r_wcnt  <= '0;
      r_is_wr <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_bus   <= w_bus_d;
      r_lhi   <= w_lhi_d;
      r_llo   <= w_llo_d;
      r_wr    <= w_wr_d;
      r_ind   <= w_ind_d;
      r_rdone <= w_rdone_d;
      r_wdone <= w_wdone_d;
      r_lane  <= w_lane_d;
      r_wcnt  <= w_wcnt_d;
      if (w_cap_wr)      r_is_wr <= 1'b1;
      else if (w_cap_rd) r_is_wr <= 1'b0;
      if (w_rdone_d)     r_rdata <= w_rbuf_d;
    end
  end

  // Captured request fields and the read assembly buffer need no reset.
  always_ff @(posedge clk) begin
    if (w_cap_wr) begin
      r_addr  <= waddr;
      r_wdata <= wdata;
      r_mask  <= wmask;
    end else if (w_cap_rd) begin
      r_addr  <= raddr;
    end
    r_rbuf <= w_rbuf_d;
  end

  assign bus_out  = r_bus;
  assign latch_hi = r_lhi;
  assign latch_lo = r_llo;
  assign write    = r_wr;
  assign ind      = r_ind;
  assign rdone    = r_rdone;
  assign wdone    = r_wdone;
  assign rdata    = r_rdata;

endmodule

// File: tb/tb_ext_bus_bridge.sv
// Bench for ext_bus_bridge: three configurations (RV16/W0, RV32/W0, RV32/W2)
// driven from a vector table, directed corner sequences and random transactions.
module tb_ext_bus_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  bus;
    logic        lhi;
    logic        llo;
    logic        wr;
    logic [1:0]  ind;
    logic        rdone;
    logic        wdone;
    logic [31:0] rdata;
  } obs_t;

  typedef struct {
    int          d;
    bit          wr;
    logic [15:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rdb;
    int          stall;
    int          done;
    logic [31:0] rdata;
  } vec_t;

  logic [2:0]  rst, rreq, wsel;
  logic [15:0] raddr_b, waddr_b;
  logic [3:0]  wmask_b;
  logic [31:0] wdata_b;
  logic        bus_ready;
  logic [7:0]  rd_bytes [4];
  int          n_tests = 0;
  int          n_fail  = 0;
  obs_t        exp_q[$];
  logic [31:0] exp_rdata [3];

  // DUT 0: RV=16, WAIT_CYCLES=0
  logic [15:0] d0_rdata;
  logic        d0_rdone, d0_wdone, d0_lhi, d0_llo, d0_wr;
  logic [7:0]  d0_bus, d0_bin;
  logic [0:0]  d0_ind;
  logic [1:0]  d0_wmask;
  assign d0_wmask = wsel[0] ? wmask_b[1:0] : 2'b00;
  assign d0_bin   = rd_bytes[{1'b0, d0_ind}];

  ext_bus_bridge #(.RV(16), .WAIT_CYCLES(0)) u_d0 (
    .clk(clk), .reset_in(rst[0]), .raddr(raddr_b[15:1]), .rreq(rreq[0]),
    .rdata(d0_rdata), .rdone(d0_rdone), .waddr(waddr_b[15:1]), .wmask(d0_wmask),
    .wdata(wdata_b[15:0]), .wdone(d0_wdone), .bus_out(d0_bus), .bus_in(d0_bin),
`ifdef EXT_BUS_READY_EN
    .bus_ready(bus_ready),
`endif
    .latch_hi(d0_lhi), .latch_lo(d0_llo), .write(d0_wr), .ind(d0_ind)
  );

  // DUT 1: RV=32, WAIT_CYCLES=0
  logic [31:0] d1_rdata;
  logic        d1_rdone, d1_wdone, d1_lhi, d1_llo, d1_wr;
  logic [7:0]  d1_bus, d1_bin;
  logic [1:0]  d1_ind;
  logic [3:0]  d1_wmask;
  assign d1_wmask = wsel[1] ? wmask_b : 4'b0000;
  assign d1_bin   = rd_bytes[d1_ind];

  ext_bus_bridge #(.RV(32), .WAIT_CYCLES(0)) u_d1 (
    .clk(clk), .reset_in(rst[1]), .raddr(raddr_b[15:2]), .rreq(rreq[1]),
    .rdata(d1_rdata), .rdone(d1_rdone), .waddr(waddr_b[15:2]), .wmask(d1_wmask),
    .wdata(wdata_b), .wdone(d1_wdone), .bus_out(d1_bus), .bus_in(d1_bin),
`ifdef EXT_BUS_READY_EN
    .bus_ready(bus_ready),
`endif
    .latch_hi(d1_lhi), .latch_lo(d1_llo), .write(d1_wr), .ind(d1_ind)
  );

  // DUT 2: RV=32, WAIT_CYCLES=2
  logic [31:0] d2_rdata;
  logic        d2_rdone, d2_wdone, d2_lhi, d2_llo, d2_wr;
  logic [7:0]  d2_bus, d2_bin;
  logic [1:0]  d2_ind;
  logic [3:0]  d2_wmask;
  assign d2_wmask = wsel[2] ? wmask_b : 4'b0000;
  assign d2_bin   = rd_bytes[d2_ind];

  ext_bus_bridge #(.RV(32), .WAIT_CYCLES(2)) u_d2 (
    .clk(clk), .reset_in(rst[2]), .raddr(raddr_b[15:2]), .rreq(rreq[2]),
    .rdata(d2_rdata), .rdone(d2_rdone), .waddr(waddr_b[15:2]), .wmask(d2_wmask),
    .wdata(wdata_b), .wdone(d2_wdone), .bus_out(d2_bus), .bus_in(d2_bin),
`ifdef EXT_BUS_READY_EN
    .bus_ready(bus_ready),
`endif
    .latch_hi(d2_lhi), .latch_lo(d2_llo), .write(d2_wr), .ind(d2_ind)
  );

  function automatic obs_t get_obs(input int d);
    obs_t o;
    o = '0;
    if (d == 0) begin
      o.bus = d0_bus; o.lhi = d0_lhi; o.llo = d0_llo; o.wr = d0_wr; o.ind = {1'b0, d0_ind};
      o.rdone = d0_rdone; o.wdone = d0_wdone; o.rdata = {16'h0000, d0_rdata};
    end else if (d == 1) begin
      o.bus = d1_bus; o.lhi = d1_lhi; o.llo = d1_llo; o.wr = d1_wr; o.ind = d1_ind;
      o.rdone = d1_rdone; o.wdone = d1_wdone; o.rdata = d1_rdata;
    end else begin
      o.bus = d2_bus; o.lhi = d2_lhi; o.llo = d2_llo; o.wr = d2_wr; o.ind = d2_ind;
      o.rdone = d2_rdone; o.wdone = d2_wdone; o.rdata = d2_rdata;
    end
    return o;
  endfunction

  // Reference: expected per-cycle outputs from cycle 1 through the idle cycle after done.
  function automatic void build_exp(input int d, input bit wr, input logic [15:0] addr,
                                    input logic [3:0] mask, input logic [31:0] wdata,
                                    input int stall);
    int nb, w, extra;
    bit first;
    logic [7:0]  lo_mask;
    logic [31:0] rd;
    obs_t base, o;
    nb      = (d == 0) ? 2 : 4;
    w       = (d == 2) ? 2 : 0;
    lo_mask = (d == 0) ? 8'hFE : 8'hFC;
    rd      = '0;
    first   = 1'b1;
    exp_q.delete();
    base = '0;
    base.rdata = exp_rdata[d];
    o = base; o.bus = addr[15:8]; o.lhi = 1'b1; exp_q.push_back(o);
    o = base; o.bus = addr[7:0] & lo_mask; o.llo = 1'b1; exp_q.push_back(o);
    for (int lane = 0; lane < nb; lane++) begin
      if (wr && !mask[lane]) continue;
      rd[8*lane +: 8] = rd_bytes[lane];
      extra = first ? stall : 0;
      first = 1'b0;
      for (int k = 0; k <= w + extra; k++) begin
        o = base;
        o.ind = 2'(lane);
        o.wr  = wr;
        o.bus = wr ? wdata[8*lane +: 8] : 8'h00;
        exp_q.push_back(o);
      end
    end
    o = base;
    if (wr) o.wdone = 1'b1;
    else begin
      o.rdone = 1'b1;
      o.rdata = rd;
      exp_rdata[d] = rd;
    end
    exp_q.push_back(o);
    o = '0;
    o.rdata = exp_rdata[d];
    exp_q.push_back(o);
  endfunction

  task automatic check_obs(input string nm, input int c, input obs_t got, input obs_t want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc%0d: got bus=%02h hi=%b lo=%b wr=%b ind=%0d rdone=%b wdone=%b rdata=%08h, want bus=%02h hi=%b lo=%b wr=%b ind=%0d rdone=%b wdone=%b rdata=%08h",
               nm, c, got.bus, got.lhi, got.llo, got.wr, got.ind, got.rdone, got.wdone, got.rdata,
               want.bus, want.lhi, want.llo, want.wr, want.ind, want.rdone, want.wdone, want.rdata);
    end
  endtask

  task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h, want %08h", nm, got, want);
    end
  endtask

  // Starts and ends on a negedge; request dropped in the cycle done is seen.
  task automatic run_txn(input int d, input bit wr, input logic [15:0] addr, input logic [3:0] mask,
                         input logic [31:0] wdata, input int stall,
                         output int done_cyc, output logic [31:0] rdata_at);
    obs_t o;
    int n;
    build_exp(d, wr, addr, mask, wdata, stall);
    n = exp_q.size();
    bus_ready = 1'b1;
    if (wr) begin
      waddr_b = addr; wdata_b = wdata; wmask_b = mask; wsel = 3'(1 << d);
    end else begin
      raddr_b = addr; rreq[d] = 1'b1;
    end
    done_cyc = -1;
    rdata_at = '0;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      @(negedge clk);
      o = get_obs(d);
      check_obs($sformatf("txn_d%0d_%s", d, wr ? "wr" : "rd"), c, o, exp_q[c-1]);
      if ((o.rdone || o.wdone) && done_cyc < 0) begin
        done_cyc = c;
        rdata_at = o.rdata;
        if (wr) begin wsel = '0; wmask_b = '0; end
        else rreq[d] = 1'b0;
      end
      if (c == 1) begin
        waddr_b = 16'($urandom);
        wdata_b = $urandom;
        if (!wr) raddr_b = 16'($urandom);
      end
      bus_ready = !(stall > 0 && c >= 3 && c < 3 + stall);
    end
    if (done_cyc < 0) begin
      wsel = '0; wmask_b = '0; rreq[d] = 1'b0;
    end
    bus_ready = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vq[$];
    vec_t        v;
    int          dc;
    logic [31:0] rv;
    obs_t        z;

    rst = 3'b111; rreq = '0; wsel = '0; wmask_b = '0;
    raddr_b = '0; waddr_b = '0; wdata_b = '0; bus_ready = 1'b1;
    for (int b = 0; b < 4; b++) rd_bytes[b] = 8'h00;
    for (int d = 0; d < 3; d++) exp_rdata[d] = '0;

    vq.push_back('{d:0, wr:1'b1, addr:16'h1234, mask:4'b0011, wdata:32'h0000BEEF, rdb:32'h0, stall:0, done:5,  rdata:32'h0});
    vq.push_back('{d:1, wr:1'b1, addr:16'h5678, mask:4'b1010, wdata:32'hAABBCCDD, rdb:32'h0, stall:0, done:5,  rdata:32'h0});
    vq.push_back('{d:2, wr:1'b0, addr:16'h4321, mask:4'b0000, wdata:32'h0, rdb:32'h44332211, stall:0, done:15, rdata:32'h44332211});
    vq.push_back('{d:0, wr:1'b0, addr:16'h00A2, mask:4'b0000, wdata:32'h0, rdb:32'h0000C33C, stall:0, done:5,  rdata:32'h0000C33C});
    vq.push_back('{d:1, wr:1'b1, addr:16'h0F00, mask:4'b0001, wdata:32'h12345678, rdb:32'h0, stall:0, done:4,  rdata:32'h0});
    vq.push_back('{d:1, wr:1'b0, addr:16'h8000, mask:4'b0000, wdata:32'h0, rdb:32'hDEADBEEF, stall:0, done:7,  rdata:32'hDEADBEEF});
    vq.push_back('{d:2, wr:1'b1, addr:16'hFFFC, mask:4'b1111, wdata:32'h01020304, rdb:32'h0, stall:0, done:15, rdata:32'h0});
    vq.push_back('{d:2, wr:1'b1, addr:16'h0004, mask:4'b1000, wdata:32'hCAFEF00D, rdb:32'h0, stall:0, done:6,  rdata:32'h0});
`ifdef EXT_BUS_READY_EN
    vq.push_back('{d:0, wr:1'b0, addr:16'h2468, mask:4'b0000, wdata:32'h0, rdb:32'h00007E81, stall:4, done:9,  rdata:32'h00007E81});
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    z = '0;
    for (int d = 0; d < 3; d++) check_obs($sformatf("reset_d%0d", d), 0, get_obs(d), z);
    rst = 3'b000;

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      for (int b = 0; b < 4; b++) rd_bytes[b] = v.rdb[8*b +: 8];
      run_txn(v.d, v.wr, v.addr, v.mask, v.wdata, v.stall, dc, rv);
      check_val($sformatf("vec%0d_done_cyc", i), 32'(dc), 32'(v.done));
      if (!v.wr) check_val($sformatf("vec%0d_rdata", i), rv, v.rdata);
    end

    // Read and write requested together: write first, read follows.
    rd_bytes[0] = 8'h3C; rd_bytes[1] = 8'h96;
    raddr_b = 16'h9ABC;
    rreq[0] = 1'b1;
    run_txn(0, 1'b1, 16'h1357, 4'b0001, 32'h000000F0, 0, dc, rv);
    check_val("prio_wdone_cyc", 32'(dc), 32'd4);
    run_txn(0, 1'b0, 16'h9ABC, 4'b0000, 32'h0, 0, dc, rv);
    check_val("prio_rdone_cyc", 32'(dc), 32'd5);
    check_val("prio_rdata", rv, 32'h0000963C);

    // Reset in the second read lane, then a fresh read.
    rd_bytes[0] = 8'h5A; rd_bytes[1] = 8'hA5;
    raddr_b = 16'h3C3C;
    rreq[0] = 1'b1;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_val("rst_pre_ind", {31'b0, d0_ind}, 32'd1);
    rst[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_obs("rst_mid_read", 0, get_obs(0), z);
    rst[0] = 1'b0;
    exp_rdata[0] = '0;
    run_txn(0, 1'b0, 16'h3C3C, 4'b0000, 32'h0, 0, dc, rv);
    check_val("post_rst_rdone_cyc", 32'(dc), 32'd5);
    check_val("post_rst_rdata", rv, 32'h0000A55A);

    for (int i = 0; i < 40; i++) begin
      int d, nb;
      bit wr;
      logic [3:0] m;
      d  = $urandom_range(0, 2);
      nb = (d == 0) ? 2 : 4;
      wr = 1'($urandom_range(0, 1));
      m  = 4'($urandom_range(1, (1 << nb) - 1));
      for (int b = 0; b < 4; b++) rd_bytes[b] = 8'($urandom);
      run_txn(d, wr, 16'($urandom), m, $urandom, 0, dc, rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ext_bus_bridge.md
Name: ext_bus_bridge

Overview:
- Parametrised successor of the tile's CPU-to-pins memory bridge.
- Serialises CPU word reads and byte-masked writes onto an 8-bit multiplexed external bus: two address latch phases, then one phase per byte lane.
- Generalised over CPU word width and wait states; skips disabled write lanes; holds each data phase for a programmable number of cycles.
- Sits between the cpu core's raddr/rreq/rdone and waddr/wmask/wdone ports and the tile's dedicated/bidirectional pins.

Parameters:
- RV, 16, CPU data width in bits; legal values 16 or 32. NB = RV/8 byte lanes; IW = log2(NB) (1 or 2).
- WAIT_CYCLES, 0, extra cycles each data phase is held (0..7).

Ports:
- clk  in  1  clock
- reset_in  in  1  synchronous, active-high reset
- raddr  in  16-IW  read word address (bits 15:IW)
- rreq  in  1  read request, level; held until rdone
- rdata  out  RV  read data; valid when rdone=1, held until next read completes
- rdone  out  1  one-cycle read-complete pulse
- waddr  in  16-IW  write word address
- wmask  in  NB  byte-lane write enables; nonzero = write request, held until wdone
- wdata  in  RV  write data
- wdone  out  1  one-cycle write-complete pulse
- bus_out  out  8  address/data byte to pins
- bus_in  in  8  read byte from pins
- latch_hi  out  1  external address-high latch strobe
- latch_lo  out  1  external address-low latch strobe
- write  out  1  external write strobe
- ind  out  IW  byte-lane index, ORed externally into the low address bits

Behaviour:
- All outputs registered. Reset values: bus_out=0, latch_hi=0, latch_lo=0, write=0, ind=0, rdone=0, wdone=0, rdata=0; state=IDLE.
- States: IDLE, AHI, ALO, WDAT, RDAT, DONE.
- IDLE:
  - If wmask!=0, capture waddr/wdata/wmask -> AHI. Writes have priority when rreq and wmask are both asserted.
  - Else if rreq, capture raddr -> AHI.
- AHI, 1 cycle: bus_out=addr[15:8], latch_hi=1.
- ALO, 1 cycle: bus_out={addr[7:IW], IW'b0}, latch_lo=1. Next state is WDAT (write) or RDAT (read).
- WDAT: visits enabled lanes only, in ascending order.
  - Each lane lasts WAIT_CYCLES+1 cycles: bus_out=wdata lane byte, ind=lane, write=1 throughout.
  - After the last enabled lane -> DONE.
- RDAT: visits all lanes 0..NB-1.
  - Each lane lasts WAIT_CYCLES+1 cycles with ind=lane and write=0.
  - bus_in is sampled into rdata[8*lane+:8] on the final cycle of the lane.
  - After lane NB-1 -> DONE.
- DONE, 1 cycle: pulses wdone or rdone, all strobes 0 -> IDLE. The CPU drops its request in the cycle it sees done; IDLE then re-evaluates.
- Latency, with acceptance in cycle 0:
  - Write with k enabled lanes: wdone in cycle 3+k*(WAIT_CYCLES+1).
  - Read: rdone in cycle 3+NB*(WAIT_CYCLES+1).
- Request inputs are ignored outside IDLE. Changes to address/data/mask mid-transaction have no effect.
- Exactly one of latch_hi, latch_lo, write is high in any cycle, or none.
- reset_in mid-transaction: next cycle is IDLE with all outputs at reset values. No done pulse is issued. rdata is cleared.
- Lane counter wraps only via the DONE transition; never indexes beyond NB-1.

Optional Feature:
- EXT_BUS_READY_EN defined:
  - Adds input port bus_ready (1 bit).
  - The final cycle of any WDAT/RDAT lane (after the WAIT_CYCLES count) repeats until bus_ready=1.
  - The read sample is taken in the cycle bus_ready=1.
  - AHI/ALO are unaffected.
- Undefined: no port; fixed timing as above.

Decomposition:
- Shared package ext_bus_pkg holds:
  - state encoding (3-bit: IDLE=0, AHI=1, ALO=2, WDAT=3, RDAT=4, DONE=5)
  - RV-derived constants NB/IW
  - WAIT_CYCLES width constant (3 bits)
- Sub-module ext_bus_lane_seq: given mask, current lane and a step strobe, produces next enabled lane and a last-lane flag. Reads use an all-ones mask.

Test Plan:
- RV=16, W=0: write waddr=0x1234>>1, wmask=2'b11, wdata=0xBEEF.
  - c1: bus_out=0x12, latch_hi.
  - c2: 0x34, latch_lo.
  - c3: 0xEF, ind=0, write.
  - c4: 0xBE, ind=1, write.
  - c5: wdone.
- RV=32, W=0: wmask=4'b1010, wdata=0xAABBCCDD.
  - Data phases are only 0xCC/ind=1 then 0xAA/ind=3.
  - wdone in cycle 5.
- RV=32, W=2: read with bus_in driven per ind as 0x11,0x22,0x33,0x44.
  - Each ind is held 3 cycles.
  - rdone in cycle 15 with rdata=0x44332211.
- rreq and wmask=2'b01 asserted together: write serviced first (wdone). With rreq still high, the read starts 1 cycle after DONE and completes with rdone.
- reset_in asserted during the second RDAT lane: next cycle all strobes 0, no rdone, rdata=0. A new request after reset completes normally.
- EXT_BUS_READY_EN, RV=16, W=0: bus_ready held low 4 cycles in lane 0.
  - ind=0 is held 5 cycles.
  - Sample taken on the ready cycle.
  - rdone delayed by exactly 4 cycles.
